// File: rtl/conv_winctrl_pkg.sv
// Shared constants and FSM state type for the convolution window sequencer.
package conv_winctrl_pkg;

  localparam int unsigned PIX_W   = 8;
  localparam int unsigned KER_DIM = 3;
  localparam int unsigned NUM_LB  = 4;
  localparam int unsigned ROW_W   = KER_DIM * PIX_W;
  localparam int unsigned WIN_W   = KER_DIM * ROW_W;

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } state_t;

endpackage

// File: rtl/line_buffer.sv
// One image line of pixel storage: single write port, asynchronous read of
// three horizontally adjacent pixels starting at i_rd_col.
module line_buffer
  import conv_winctrl_pkg::*;
#(
  parameter int unsigned IMG_WIDTH = 512
) (
  input  logic                         i_clk,
  input  logic                         i_wr_en,
  input  logic [PIX_W-1:0]             i_wr_data,
  input  logic [$clog2(IMG_WIDTH)-1:0] i_wr_col,
  input  logic [$clog2(IMG_WIDTH)-1:0] i_rd_col,
  output logic [ROW_W-1:0]             o_rd_data
);

  localparam int unsigned COL_W = $clog2(IMG_WIDTH);

  logic [PIX_W-1:0] mem [IMG_WIDTH];

  // Pixel store; contents are not reset.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) mem[i_wr_col] <= i_wr_data;
  end

  // Leftmost pixel of the triple lands in the low byte.
  always_comb begin
    o_rd_data = {mem[i_rd_col + COL_W'(2)], mem[i_rd_col + COL_W'(1)], mem[i_rd_col]};
  end

endmodule

// File: rtl/conv_window_ctrl.sv
// Line-buffer sequencer feeding 3x3 windows to the conv datapath.
// Optional macro CONV_WINCTRL_OVF_FLAG_EN enables the sticky o_overflow flag.
module conv_window_ctrl
  import conv_winctrl_pkg::*;
#(
  parameter int unsigned IMG_WIDTH = 512
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [PIX_W-1:0] i_pixel_data,
  input  logic             i_pixel_data_valid,
  output logic             o_in_ready,
  output logic [WIN_W-1:0] o_pixel_data,
  output logic             o_pixel_data_valid,
  output logic             o_intr,
  output logic             o_overflow
);

  localparam int unsigned COL_W = $clog2(IMG_WIDTH);
  localparam int unsigned CNT_W = $clog2(NUM_LB * IMG_WIDTH + 1);

  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(NUM_LB * IMG_WIDTH);
  localparam logic [CNT_W-1:0] START_CNT = CNT_W'(KER_DIM * IMG_WIDTH);
  localparam logic [CNT_W-1:0] LINE_CNT  = CNT_W'(IMG_WIDTH);
  localparam logic [COL_W-1:0] LAST_WR   = COL_W'(IMG_WIDTH - 1);
  localparam logic [COL_W-1:0] LAST_RD   = COL_W'(IMG_WIDTH - KER_DIM);

  state_t             state, state_nxt;
  logic [COL_W-1:0]   wr_col, rd_col, rd_col_nxt;
  logic [1:0]         wr_sel, rd_sel;
  logic [CNT_W-1:0]   fill_cnt, fill_nxt;
  logic               wr_en, line_done, win_vld;
  logic [NUM_LB-1:0]  lb_wr_en;
  logic [ROW_W-1:0]   lb_rd [NUM_LB];
  logic [WIN_W-1:0]   win;

  assign wr_en = i_pixel_data_valid & o_in_ready;

  for (genvar g = 0; g < NUM_LB; g++) begin : g_lb
    assign lb_wr_en[g] = wr_en && (wr_sel == 2'(g));
    line_buffer #(.IMG_WIDTH(IMG_WIDTH)) u_lb (
      .i_clk     (i_clk),
      .i_wr_en   (lb_wr_en[g]),
      .i_wr_data (i_pixel_data),
      .i_wr_col  (wr_col),
      .i_rd_col  (rd_col),
      .o_rd_data (lb_rd[g])
    );
  end

  // Next state, read column and line-done strobe.
  always_comb begin
    state_nxt  = state;
    rd_col_nxt = rd_col;
    line_done  = 1'b0;
    win_vld    = 1'b0;
    case (state)
      IDLE: begin
        if (fill_cnt >= START_CNT) begin
          state_nxt  = READ;
          rd_col_nxt = '0;
        end
      end
      READ: begin
        win_vld = 1'b1;
        if (rd_col == LAST_RD) begin
          line_done = 1'b1;
          state_nxt = IDLE;
        end else begin
          rd_col_nxt = rd_col + COL_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stored-pixel count; a write and a line-done in one cycle net to 1-IMG_WIDTH.
  always_comb begin
    fill_nxt = fill_cnt;
    if (wr_en)     fill_nxt = fill_nxt + CNT_W'(1);
    if (line_done) fill_nxt = fill_nxt - LINE_CNT;
  end

  // Oldest buffered line forms row 0, the next two rows follow in rotation.
  always_comb begin
    win = '0;
    for (int unsigned r = 0; r < KER_DIM; r++) begin
      win[r*ROW_W +: ROW_W] = lb_rd[rd_sel + 2'(r)];
    end
  end

  // Control state, counters and buffer selects.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      rd_col     <= '0;
      wr_col     <= '0;
      wr_sel     <= '0;
      rd_sel     <= '0;
      fill_cnt   <= '0;
      o_in_ready <= 1'b1;
    end else begin
      state      <= state_nxt;
      rd_col     <= rd_col_nxt;
      fill_cnt   <= fill_nxt;
      o_in_ready <= (fill_nxt < FULL_CNT);
      if (wr_en) begin
        if (wr_col == LAST_WR) begin
          wr_col <= '0;
          wr_sel <= wr_sel + 2'd1;
        end else begin
          wr_col <= wr_col + COL_W'(1);
        end
      end
      if (line_done) rd_sel <= rd_sel + 2'd1;
    end
  end

  // Registered window, valid and line-freed interrupt.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_pixel_data       <= '0;
      o_pixel_data_valid <= 1'b0;
      o_intr             <= 1'b0;
    end else begin
      o_pixel_data_valid <= win_vld;
      o_intr             <= line_done;
      if (win_vld) o_pixel_data <= win;
    end
  end

`ifdef CONV_WINCTRL_OVF_FLAG_EN
  // Sticky flag for any write attempted while the buffers are full.
  always_ff @(posedge i_clk) begin
    if (i_rst) o_overflow <= 1'b0;
    else if (i_pixel_data_valid && !o_in_ready) o_overflow <= 1'b1;
  end
`else
  assign o_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Self-checking bench for conv_window_ctrl with IMG_WIDTH = 8.
module tb_conv_window_ctrl;
  import conv_winctrl_pkg::*;

  localparam int unsigned W  = 8;
  localparam int unsigned NW = W - 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  pd  = '0;
  logic        pv  = 1'b0;
  logic        in_ready, win_valid, intr, overflow;
  logic [71:0] win_data;

  always #5 clk = ~clk;

  conv_window_ctrl #(.IMG_WIDTH(W)) dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_pixel_data       (pd),
    .i_pixel_data_valid (pv),
    .o_in_ready         (in_ready),
    .o_pixel_data       (win_data),
    .o_pixel_data_valid (win_valid),
    .o_intr             (intr),
    .o_overflow         (overflow)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned cyc   = 0;
  int unsigned win_seen;
  int unsigned n_intr;
  byte unsigned pix[$];
  int unsigned  vlog[$];
  logic [71:0]  wlog[$];

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Window n of the raster: line n/NW, column n%NW, rows from three consecutive lines.
  function automatic logic [71:0] model_win(input int unsigned n);
    int unsigned l = n / NW;
    int unsigned c = n % NW;
    logic [71:0] w = '0;
    for (int k = 0; k < 9; k++) w[k*8 +: 8] = pix[(l + k/3)*W + c + k%3];
    return w;
  endfunction

  function automatic bit model_avail(input int unsigned n);
    return pix.size() >= (n / NW + 3) * W;
  endfunction

  function automatic int unsigned model_stored();
    return pix.size() - W * (win_seen / NW);
  endfunction

  task automatic step(input bit v, input logic [7:0] d);
    bit exp_rdy;
    exp_rdy = model_stored() < 4 * W;
    check("in_ready", in_ready, exp_rdy);
    pv = v;
    pd = d;
    @(posedge clk);
    #1;
    cyc++;
    pv = 1'b0;
    if (v && exp_rdy) pix.push_back(d);
    if (win_valid) begin
      if (!model_avail(win_seen)) begin
        check("spurious_valid", 1'b1, 1'b0);
      end else begin
        check("window", win_data, model_win(win_seen));
        check("intr_last", intr, (win_seen % NW) == NW - 1);
      end
      vlog.push_back(cyc);
      wlog.push_back(win_data);
      win_seen++;
    end else begin
      check("intr_idle", intr, 1'b0);
    end
    if (intr) n_intr++;
    check("fill_cnt", 72'(dut.fill_cnt), 72'(model_stored()));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pv  = 1'b0;
    pd  = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    pix.delete();
    vlog.delete();
    wlog.delete();
    win_seen = 0;
    n_intr   = 0;
    check("rst_valid", win_valid, 1'b0);
    check("rst_data", win_data, 72'h0);
    check("rst_intr", intr, 1'b0);
    check("rst_ready", in_ready, 1'b1);
    check("rst_ovf", overflow, 1'b0);
  endtask

  task automatic drain(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(1'b0, 8'h00);
  endtask

  initial begin
    int unsigned wcyc;
    int unsigned lines;

    // First line: pixels 0..23
    do_reset();
    for (int i = 0; i < 24; i++) step(1'b1, 8'(i));
    wcyc = cyc;
    drain(14);
    check("first_cnt", 72'(win_seen), 72'(NW));
    check("first_intrs", 72'(n_intr), 72'd1);
    if (vlog.size() >= NW) begin
      check("first_latency", 72'(vlog[0]), 72'(wcyc + 2));
      check("first_consec", 72'(vlog[NW-1] - vlog[0]), 72'(NW - 1));
      check("first_win0", wlog[0], 72'h12_11_10_0A_09_08_02_01_00);
      check("first_win5", wlog[NW-1], 72'h17_16_15_0F_0E_0D_07_06_05);
    end else begin
      check("first_wins_present", 72'(vlog.size()), 72'(NW));
    end

    // Continuous stream: pixels 0..47
    do_reset();
    for (int i = 0; i < 48; i++) step(1'b1, 8'(i));
    drain(20);
    check("stream_cnt", 72'(win_seen), 72'(4 * NW));
    check("stream_intrs", 72'(n_intr), 72'd4);
    if (wlog.size() > 3 * NW) begin
      check("stream_l4_row0", 72'(wlog[3*NW][23:0]), 72'h1A_19_18);
      for (int l = 0; l < 4; l++)
        check("stream_consec", 72'(vlog[l*NW + NW - 1] - vlog[l*NW]), 72'(NW - 1));
    end else begin
      check("stream_wins_present", 72'(wlog.size()), 72'(4 * NW));
    end

    // Full condition with reading held off, then back-to-back line drain
    do_reset();
    force dut.state = IDLE;
    for (int i = 0; i < 32; i++) step(1'b1, 8'($urandom));
    step(1'b1, 8'hFF);
    check("full_ready", in_ready, 1'b0);
    check("full_fill", 72'(dut.fill_cnt), 72'd32);
    check("full_stored", 72'(pix.size()), 72'd32);
`ifdef CONV_WINCTRL_OVF_FLAG_EN
    check("full_ovf", overflow, 1'b1);
`else
    check("full_ovf", overflow, 1'b0);
`endif
    release dut.state;
    drain(40);
    check("full_drain_cnt", 72'(win_seen), 72'(2 * NW));
    if (vlog.size() > NW)
      check("line_gap", 72'(vlog[NW] - vlog[NW-1]), 72'd2);
    else
      check("line_gap_present", 72'(vlog.size()), 72'(2 * NW));

    // Reset in the middle of a READ pass
    do_reset();
    for (int i = 0; i < 24; i++) step(1'b1, 8'($urandom));
    for (int i = 0; i < 20 && win_seen < 3; i++) step(1'b0, 8'h00);
    check("rd3_reached", 72'(win_seen), 72'd3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_valid_drop", win_valid, 1'b0);
    do_reset();
    for (int i = 0; i < 23; i++) step(1'b1, 8'($urandom));
    drain(5);
    check("midrst_no_win", 72'(win_seen), 72'd0);
    step(1'b1, 8'($urandom));
    drain(12);
    check("midrst_refill", 72'(win_seen), 72'(NW));

    // Randomized stream with idle gaps
    do_reset();
    for (int i = 0; i < 200; i++) step($urandom_range(0, 3) != 0, 8'($urandom));
    drain(40);
    lines = pix.size() / W;
    check("rand_cnt", 72'(win_seen), 72'((lines >= 3) ? (lines - 2) * NW : 0));
    check("rand_intrs", 72'(n_intr), 72'((lines >= 3) ? lines - 2 : 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
